// File: rtl/cpu_types_pkg.sv
// Shared CPU memory-side types: RAM word, RAM handshake state and arbiter FSM state.
package cpu_types_pkg;

   localparam int unsigned WORD_W = 32;

   typedef logic [WORD_W-1:0] word_t;

   typedef enum logic [1:0] {
      FREE   = 2'd0,
      BUSY   = 2'd1,
      ACCESS = 2'd2,
      ERROR  = 2'd3
   } ramstate_t;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      IGRANT = 2'd1,
      DGRANT = 2'd2
   } arb_state_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Cache-side request/response signals and RAM-side strobes of the memory arbiter.
interface mem_arbiter_if;
   import cpu_types_pkg::*;

   logic      iREN;
   word_t     iaddr;
   logic      iwait;
   word_t     iload;

   logic      dREN;
   logic      dWEN;
   word_t     daddr;
   word_t     dstore;
   logic      dwait;
   word_t     dload;

   logic      ramREN;
   logic      ramWEN;
   word_t     ramaddr;
   word_t     ramstore;
   word_t     ramload;
   ramstate_t ramstate;

   // Arbiter view.
   modport slave (
      input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
      output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
   );

   // Caches plus RAM view.
   modport master (
      output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
      input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
   );

endinterface

// File: rtl/arb_starve_ctr.sv
// Saturating counter of dcache completions granted while an instruction fetch waits.
module arb_starve_ctr #(
   parameter int unsigned LIMIT = 4,
   parameter int unsigned CNT_W = $clog2(LIMIT + 1)
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             inc,
   input  logic             clr,
   output logic [CNT_W-1:0] cnt,
   output logic             sat
);

   assign sat = (cnt == CNT_W'(LIMIT));

   // Clear beats increment; increment holds once saturated.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (inc && !sat) begin
         cnt <= cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter: dcache has priority, instruction fetch is forced through
// after STARVE_LIMIT back-to-back dcache completions.
module mem_arbiter
   import cpu_types_pkg::*;
#(
   parameter int unsigned STARVE_LIMIT = 4
) (
   input logic          CLK,
   input logic          RST,
   mem_arbiter_if.slave bus
);

   localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);

   arb_state_t       state;
   arb_state_t       state_next;
   logic [CNT_W-1:0] starve_cnt;
   logic             starve_sat;
   logic             starve_inc;
   logic             starve_clr;
   logic             d_req;
   logic             ram_acc;

   assign d_req   = bus.dREN | bus.dWEN;
   assign ram_acc = (bus.ramstate == ACCESS);

   arb_starve_ctr #(
      .LIMIT (STARVE_LIMIT),
      .CNT_W (CNT_W)
   ) u_starve (
      .CLK (CLK),
      .RST (RST),
      .inc (starve_inc),
      .clr (starve_clr),
      .cnt (starve_cnt),
      .sat (starve_sat)
   );

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // ACCESS is checked before a strobe drop so a coinciding drop still completes.
   always_comb begin
      state_next = state;
      starve_inc = 1'b0;
      starve_clr = 1'b0;
      case (state)
         IDLE: begin
            if (bus.iREN && (!d_req || starve_sat)) begin
               state_next = IGRANT;
            end else if (d_req) begin
               state_next = DGRANT;
            end
         end
         DGRANT: begin
            if (ram_acc) begin
               state_next = IDLE;
               starve_inc = bus.iREN;
               starve_clr = !bus.iREN;
            end else if (!d_req) begin
               state_next = IDLE;
            end
         end
         IGRANT: begin
            if (ram_acc) begin
               state_next = IDLE;
               starve_clr = 1'b1;
            end else if (!bus.iREN) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // RAM strobes and waits follow the granted requester live, so a dropped strobe
   // leaves the RAM in the same cycle.
   always_comb begin
      bus.ramREN   = 1'b0;
      bus.ramWEN   = 1'b0;
      bus.ramaddr  = '0;
      bus.ramstore = '0;
      bus.iwait    = 1'b1;
      bus.dwait    = 1'b1;
      case (state)
         DGRANT: begin
            bus.ramaddr  = bus.daddr;
            bus.ramstore = bus.dstore;
            bus.ramWEN   = bus.dWEN;
            bus.ramREN   = bus.dREN & ~bus.dWEN;
            bus.dwait    = ~ram_acc;
         end
         IGRANT: begin
            bus.ramaddr = bus.iaddr;
            bus.ramREN  = bus.iREN;
            bus.iwait   = ~ram_acc;
         end
         default: ;
      endcase
   end

   assign bus.iload = bus.ramload;
   assign bus.dload = bus.ramload;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboarded bench for mem_arbiter: directed scenarios, then two random cache agents
// against a random-latency RAM, with a grant-order model built from completion history.
module tb_mem_arbiter;
   import cpu_types_pkg::*;

   localparam int unsigned LIMIT = 4;

   logic CLK;
   logic RST;

   mem_arbiter_if bus ();

   mem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
      .CLK (CLK),
      .RST (RST),
      .bus (bus)
   );

   typedef struct {
      word_t addr;
      logic  wr;
      word_t data;
   } exp_t;

   exp_t        iq[$];
   exp_t        dq[$];
   word_t       ram_mem[word_t];
   word_t       ref_mem[word_t];
   int          vectors = 0;
   int          errors  = 0;
   bit          ram_auto = 1'b0;
   ramstate_t   dir_state = FREE;
   int unsigned streak = 0;
   int unsigned prev_streak = 0;
   bit          prev_both = 1'b0;

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   function automatic word_t init_word(word_t a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
   endfunction

   function automatic word_t ram_rd(word_t a);
      return ram_mem.exists(a) ? ram_mem[a] : init_word(a);
   endfunction

   function automatic word_t ref_rd(word_t a);
      return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
   endfunction

   task automatic chk(string name, word_t got, word_t exp);
      vectors++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   task automatic chk1(string name, logic got, logic exp);
      vectors++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b", name, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge CLK);
      #1;
   endtask

   task automatic look();
      #3;
   endtask

   // RAM model: ramstate/ramload updated mid-cycle, writes committed on ACCESS.
   initial begin
      bus.ramstate = FREE;
      bus.ramload  = '0;
      forever begin
         @(posedge CLK);
         #3;
         if (ram_auto) begin
            case ($urandom_range(0, 5))
               0, 1:    bus.ramstate = ACCESS;
               2:       bus.ramstate = FREE;
               3:       bus.ramstate = ERROR;
               default: bus.ramstate = BUSY;
            endcase
         end else begin
            bus.ramstate = dir_state;
         end
         bus.ramload = ram_rd(bus.ramaddr);
         @(negedge CLK);
         if (!RST && bus.ramstate == ACCESS && bus.ramWEN) ram_mem[bus.ramaddr] = bus.ramstore;
      end
   end

   // Monitor: pops expectations on completions and checks grant order in IDLE contention.
   always @(negedge CLK) begin : monitor
      exp_t e;
      if (RST) begin
         streak    = 0;
         prev_both = 1'b0;
      end else begin
         if (!bus.iwait) begin
            if (iq.size() == 0) begin
               vectors++;
               errors++;
               $display("FAIL i_unexpected: got completion at %h expected none", bus.ramaddr);
            end else begin
               e = iq.pop_front();
               chk("i_addr", bus.ramaddr, e.addr);
               chk1("i_ren", bus.ramREN, 1'b1);
               chk("i_load", bus.iload, e.data);
            end
            streak = 0;
         end
         if (!bus.dwait) begin
            if (dq.size() == 0) begin
               vectors++;
               errors++;
               $display("FAIL d_unexpected: got completion at %h expected none", bus.ramaddr);
            end else begin
               e = dq.pop_front();
               chk("d_addr", bus.ramaddr, e.addr);
               chk1("d_wen", bus.ramWEN, e.wr);
               chk1("d_ren", bus.ramREN, !e.wr);
               if (e.wr) chk("d_store", bus.ramstore, e.data);
               else      chk("d_load", bus.dload, e.data);
            end
            if (!bus.iREN)          streak = 0;
            else if (streak < LIMIT) streak = streak + 1;
         end
         if (prev_both) begin
            chk1("grant_strobe", bus.ramREN | bus.ramWEN, 1'b1);
            chk1("grant_icache", bus.ramaddr[12], prev_streak == LIMIT);
         end
         prev_both   = !(bus.ramREN | bus.ramWEN) && bus.iREN && (bus.dREN | bus.dWEN);
         prev_streak = streak;
      end
   end

   task automatic d_agent(int n);
      for (int t = 0; t < n; t++) begin
         int   gap;
         int   waited;
         bit   w;
         bit   both;
         exp_t e;
         gap = int'($urandom_range(0, 2));
         repeat (gap) begin
            bus.dREN = 1'b0;
            bus.dWEN = 1'b0;
            cyc();
         end
         w          = ($urandom_range(0, 2) == 0);
         both       = w && ($urandom_range(0, 1) == 1);
         bus.daddr  = word_t'($urandom_range(0, 1023));
         bus.dstore = $urandom();
         bus.dWEN   = w;
         bus.dREN   = !w || both;
         e.addr     = bus.daddr;
         e.wr       = w;
         if (w) begin
            e.data = bus.dstore;
            ref_mem[e.addr] = e.data;
         end else begin
            e.data = ref_rd(e.addr);
         end
         dq.push_back(e);
         waited = 0;
         do begin
            @(negedge CLK);
            waited++;
         end while (bus.dwait && waited < 200);
         if (bus.dwait) begin
            vectors++;
            errors++;
            $display("FAIL d_timeout: got no completion for %h expected one within 200 cycles", e.addr);
         end
         cyc();
      end
      bus.dREN = 1'b0;
      bus.dWEN = 1'b0;
   endtask

   task automatic i_agent(int n);
      for (int t = 0; t < n; t++) begin
         int   gap;
         int   waited;
         exp_t e;
         gap = int'($urandom_range(0, 2));
         repeat (gap) begin
            bus.iREN = 1'b0;
            cyc();
         end
         bus.iaddr = 32'h1000 + word_t'($urandom_range(0, 255));
         bus.iREN  = 1'b1;
         e.addr    = bus.iaddr;
         e.wr      = 1'b0;
         e.data    = init_word(e.addr);
         iq.push_back(e);
         waited = 0;
         do begin
            @(negedge CLK);
            waited++;
         end while (bus.iwait && waited < 200);
         if (bus.iwait) begin
            vectors++;
            errors++;
            $display("FAIL i_timeout: got no completion for %h expected one within 200 cycles", e.addr);
         end
         cyc();
      end
      bus.iREN = 1'b0;
   endtask

   initial begin : watchdog
      #400000;
      $display("FAIL watchdog: got no finish expected finish before 40000 cycles");
      $fatal(1, "watchdog expired");
   end

   initial begin : stim
      RST        = 1'b1;
      bus.iREN   = 1'b0;
      bus.iaddr  = '0;
      bus.dREN   = 1'b0;
      bus.dWEN   = 1'b0;
      bus.daddr  = '0;
      bus.dstore = '0;
      cyc();
      cyc();
      look();
      chk1("rst_ramren", bus.ramREN, 1'b0);
      chk1("rst_ramwen", bus.ramWEN, 1'b0);
      chk("rst_ramaddr", bus.ramaddr, 32'h0);
      chk("rst_ramstore", bus.ramstore, 32'h0);
      chk1("rst_iwait", bus.iwait, 1'b1);
      chk1("rst_dwait", bus.dwait, 1'b1);
      chk("rst_state", 32'(dut.state), 32'(IDLE));
      cyc();
      RST = 1'b0;

      // Reset in the middle of a stalled dcache write.
      cyc();
      bus.dWEN = 1'b1; bus.daddr = 32'h100; bus.dstore = 32'hCAFE_F00D; dir_state = BUSY;
      cyc();
      look();
      chk1("t1_wen_granted", bus.ramWEN, 1'b1);
      chk("t1_state_dgrant", 32'(dut.state), 32'(DGRANT));
      #2 RST = 1'b1;
      #1;
      chk1("t1_rst_wen", bus.ramWEN, 1'b0);
      chk1("t1_rst_dwait", bus.dwait, 1'b1);
      chk("t1_rst_state", 32'(dut.state), 32'(IDLE));
      cyc();
      bus.dWEN = 1'b0; dir_state = FREE; RST = 1'b0;
      cyc();
      look();
      chk1("t1_idle_ren", bus.ramREN, 1'b0);
      chk1("t1_idle_wen", bus.ramWEN, 1'b0);
      chk1("t1_idle_dwait", bus.dwait, 1'b1);
      chk1("t1_idle_iwait", bus.iwait, 1'b1);
      chk("t1_idle_state", 32'(dut.state), 32'(IDLE));

      // Lone instruction fetch completing in the first grant cycle.
      ram_mem[32'h40] = 32'hDEAD_BEEF;
      ref_mem[32'h40] = 32'hDEAD_BEEF;
      bus.iREN = 1'b1; bus.iaddr = 32'h40;
      iq.push_back('{addr: 32'h40, wr: 1'b0, data: 32'hDEAD_BEEF});
      cyc();
      dir_state = ACCESS;
      look();
      chk1("t2_ramren", bus.ramREN, 1'b1);
      chk("t2_ramaddr", bus.ramaddr, 32'h40);
      chk1("t2_iwait", bus.iwait, 1'b0);
      chk("t2_iload", bus.iload, 32'hDEAD_BEEF);
      cyc();
      bus.iREN = 1'b0; dir_state = FREE;
      look();
      chk("t2_state_idle", 32'(dut.state), 32'(IDLE));
      chk1("t2_iwait_idle", bus.iwait, 1'b1);

      // Simultaneous requests: dcache first after two BUSY cycles, then icache.
      bus.iREN = 1'b1; bus.iaddr = 32'h1040; bus.dREN = 1'b1; bus.daddr = 32'h200;
      dir_state = BUSY;
      dq.push_back('{addr: 32'h200, wr: 1'b0, data: ref_rd(32'h200)});
      iq.push_back('{addr: 32'h1040, wr: 1'b0, data: init_word(32'h1040)});
      cyc();
      look();
      chk("t3_ramaddr_d", bus.ramaddr, 32'h200);
      chk1("t3_dwait_c1", bus.dwait, 1'b1);
      cyc();
      look();
      chk1("t3_dwait_c2", bus.dwait, 1'b1);
      dir_state = ACCESS;
      cyc();
      look();
      chk1("t3_dwait_c3", bus.dwait, 1'b0);
      cyc();
      bus.dREN = 1'b0; dir_state = BUSY;
      look();
      chk1("t3_idle_iwait", bus.iwait, 1'b1);
      chk1("t3_idle_ramren", bus.ramREN, 1'b0);
      cyc();
      look();
      chk("t3_ramaddr_i", bus.ramaddr, 32'h1040);
      chk1("t3_iwait_busy", bus.iwait, 1'b1);
      dir_state = ACCESS;
      cyc();
      look();
      chk1("t3_iwait_acc", bus.iwait, 1'b0);
      cyc();
      bus.iREN = 1'b0; dir_state = FREE;

      // Read and write strobes together: the write wins.
      bus.dREN = 1'b1; bus.dWEN = 1'b1; bus.daddr = 32'h300; bus.dstore = 32'h1234_5678;
      ref_mem[32'h300] = 32'h1234_5678;
      dq.push_back('{addr: 32'h300, wr: 1'b1, data: 32'h1234_5678});
      dir_state = BUSY;
      cyc();
      look();
      chk1("t4_ramwen", bus.ramWEN, 1'b1);
      chk1("t4_ramren", bus.ramREN, 1'b0);
      chk("t4_ramstore", bus.ramstore, 32'h1234_5678);
      dir_state = ACCESS;
      cyc();
      look();
      chk1("t4_dwait", bus.dwait, 1'b0);
      cyc();
      bus.dREN = 1'b0; bus.dWEN = 1'b0; dir_state = FREE;

      // Starvation: LIMIT dcache completions, then a forced fetch, twice.
      dir_state = ACCESS;
      bus.iREN = 1'b1; bus.iaddr = 32'h1080;
      bus.dREN = 1'b1; bus.dWEN = 1'b0; bus.daddr = 32'h400;
      for (int k = 0; k < 10; k++) begin
         bit    is_i;
         word_t want;
         is_i = (k % 5 == 4);
         if (is_i) iq.push_back('{addr: bus.iaddr, wr: 1'b0, data: init_word(bus.iaddr)});
         else      dq.push_back('{addr: bus.daddr, wr: 1'b0, data: ref_rd(bus.daddr)});
         want = is_i ? bus.iaddr : bus.daddr;
         cyc();
         look();
         chk("t5_grant_addr", bus.ramaddr, want);
         cyc();
         look();
         chk("t5_starve_cnt", 32'(dut.starve_cnt), is_i ? 32'd0 : 32'((k % 5) + 1));
         if (!is_i) bus.daddr = bus.daddr + 32'd1;
      end
      bus.iREN = 1'b0; bus.dREN = 1'b0; dir_state = FREE;
      cyc();

      // ERROR responses hold the fetch grant until ACCESS.
      bus.iREN = 1'b1; bus.iaddr = 32'h10C0;
      iq.push_back('{addr: 32'h10C0, wr: 1'b0, data: init_word(32'h10C0)});
      dir_state = ERROR;
      cyc();
      for (int k = 0; k < 5; k++) begin
         look();
         chk1("t6_iwait_error", bus.iwait, 1'b1);
         chk("t6_state_igrant", 32'(dut.state), 32'(IGRANT));
         if (k == 4) dir_state = ACCESS;
         cyc();
      end
      look();
      chk1("t6_iwait_acc", bus.iwait, 1'b0);
      cyc();
      bus.iREN = 1'b0; dir_state = FREE;

      // Fetch strobe dropped mid-grant after one starving dcache completion.
      bus.iREN = 1'b1; bus.iaddr = 32'h1100; bus.dREN = 1'b1; bus.daddr = 32'h500;
      dq.push_back('{addr: 32'h500, wr: 1'b0, data: ref_rd(32'h500)});
      dir_state = ACCESS;
      cyc();
      look();
      chk1("t6b_dwait", bus.dwait, 1'b0);
      cyc();
      bus.dREN = 1'b0; dir_state = BUSY;
      cyc();
      #1;
      chk1("t6b_ramren_on", bus.ramREN, 1'b1);
      bus.iREN = 1'b0;
      #1;
      chk1("t6b_ramren_drop", bus.ramREN, 1'b0);
      cyc();
      look();
      chk("t6b_state_idle", 32'(dut.state), 32'(IDLE));
      chk("t6b_starve_kept", 32'(dut.starve_cnt), 32'd1);
      dir_state = FREE;

      // Random traffic from both caches against a random-latency RAM.
      ram_auto = 1'b1;
      fork
         d_agent(80);
         i_agent(80);
      join
      ram_auto = 1'b0;
      cyc();
      cyc();
      cyc();
      chk("iq_drained", 32'(iq.size()), 32'd0);
      chk("dq_drained", 32'(dq.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

- Single-port RAM arbiter directly downstream of the dcache control unit and the icache.
- Accepts the dcache's dREN/dWEN/daddr/dstore requests and the icache's iREN/iaddr requests.
- Grants exactly one requester the RAM at a time and returns data and wait handshakes.
- Dcache has priority; a starvation counter guarantees instruction fetch forward progress.

## Interface
Parameters:
- STARVE_LIMIT, 4: consecutive dcache completions allowed while iREN is held before icache is forced a grant; legal range 1–15.

Ports:
- CLK  in  1  system clock, all state on rising edge
- RST  in  1  asynchronous, active-high reset
- iREN  in  1  icache read request
- iaddr  in  32  icache word address
- iwait  out  1  icache stall; 0 only in the completing cycle
- iload  out  32  read data to icache
- dREN  in  1  dcache read request
- dWEN  in  1  dcache write request
- daddr  in  32  dcache word address
- dstore  in  32  dcache write data
- dwait  out  1  dcache stall; 0 only in the completing cycle
- dload  out  32  read data to dcache
- ramREN  out  1  RAM read strobe
- ramWEN  out  1  RAM write strobe
- ramaddr  out  32  RAM address
- ramstore  out  32  RAM write data
- ramload  in  32  RAM read data
- ramstate  in  ramstate_t  FREE/BUSY/ACCESS/ERROR

## Operation
FSM states are IDLE, IGRANT, DGRANT.

IDLE:
- No RAM strobes.
- Transitions to DGRANT if dREN|dWEN, else IGRANT if iREN.
- Exception: if iREN, a dcache request, and starve_cnt == STARVE_LIMIT are all true, go to IGRANT.

DGRANT:
- ramaddr=daddr, ramstore=dstore.
- ramWEN=dWEN. ramREN=dREN&~dWEN, so a write wins if both are asserted.
- dwait=~(ramstate==ACCESS).
- On ACCESS: return to IDLE. If iREN, starve_cnt increments, saturating at STARVE_LIMIT; otherwise starve_cnt clears to 0.

IGRANT:
- ramaddr=iaddr, ramREN=iREN, ramWEN=0.
- iwait=~(ramstate==ACCESS).
- On ACCESS: return to IDLE and clear starve_cnt.

Load data:
- iload and dload are combinational pass-throughs of ramload.
- They are valid only while the matching wait is 0.

Requester rules:
- A requester holds its address, data and strobe stable while its wait=1.
- If a granted requester drops its strobe before ACCESS, the RAM strobes drop the same cycle and the FSM returns to IDLE at the next edge. starve_cnt is unchanged.

ramstate handling:
- ERROR and BUSY are treated as not-ACCESS; the grant is held.
- FREE while granted is also held. The RAM latency is unbounded.

## Timing
Reset values, applied asynchronously while RST=1:
- state=IDLE, starve_cnt=0.
- ramREN=0, ramWEN=0, ramaddr=0, ramstore=0.
- iwait=1, dwait=1.

Latency and handshake:
- A request sampled at edge N puts the strobe on the RAM in cycle N+1.
- Minimum completion is cycle N+1 if ramstate==ACCESS there.
- Waits are combinational from the state register and ramstate; there is no extra register stage.
- There is always one IDLE cycle between transactions. A requester that holds its strobe after completion sees wait=1 in that IDLE cycle and is re-arbitrated.

Simultaneous events:
- iREN and dREN both arrive in IDLE: dcache wins unless starve_cnt==STARVE_LIMIT.
- ACCESS coinciding with a strobe drop counts as a completion.

Reset mid-grant:
- Strobes fall immediately and the transaction is abandoned.
- No partial write is counted.

## Structure
- ramstate_t and word_t live in cpu_types_pkg.
- Add arb_state_t (IDLE, IGRANT, DGRANT) to cpu_types_pkg so benches can probe it.
- One sub-module: arb_starve_ctr.
  - Saturating up-counter with inc, clr and sat outputs.
  - Width $clog2(STARVE_LIMIT+1).
  - Same CLK/RST.
- Top-level mem_arbiter holds the FSM and the output muxes.

## Test plan
1. Reset mid-DGRANT write (dWEN=1, daddr=0x100, ramstate=BUSY), assert RST -> same cycle ramWEN=0, dwait=1, state=IDLE; after release, idle outputs hold with no request.
2. Lone iREN, iaddr=0x40, ramstate=ACCESS from the cycle after the request -> ramREN=1, ramaddr=0x40 in cycle 1; iwait=0 and iload=ramload (0xDEADBEEF) in cycle 1; IDLE in cycle 2.
3. iREN and dREN both asserted at once, ramstate ACCESS after 2 BUSY cycles -> dcache granted first (ramaddr=daddr=0x200), dwait low in cycle 3; icache granted next.
4. dREN and dWEN both 1, dstore=0x12345678 -> ramWEN=1, ramREN=0, ramstore=0x12345678.
5. STARVE_LIMIT=4, iREN held and dcache requesting continuously -> exactly 4 dcache completions, then an IGRANT; starve_cnt=0 after icache ACCESS; the pattern repeats.
6. ramstate=ERROR for 5 cycles during IGRANT, then ACCESS -> iwait stays 1 through the ERROR cycles and falls only on ACCESS. Separately, iREN dropped mid-grant -> ramREN=0 the same cycle, IDLE the next cycle, starve_cnt unchanged.
